// File: rtl/fft_bit_reverse_pkg.sv
// Shared FMCW FFT dimensions and the index bit-reversal helper.
// Used by the FFT output reorder path; no timing or flow control of its own.
package fft_bit_reverse_pkg;

    localparam int FMCW_FFT_N     = 1024;
    localparam int FMCW_FFT_NLOG2 = 10;
    localparam int FMCW_DW        = 25;

    // Reverses the low nbits of x; bits at and above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[i] = x[nbits-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_ram.sv
// Simple dual-port frame store: one write port and a registered, enabled read port.
// Read data 1 cycle after a read enable; no backpressure, the output holds while re_i is low.
module fft_bitrev_ram #(
    parameter int AW = 11,
    parameter int W  = 50
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is cleared; the array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bit_reverse.sv
// Reorders bit-reversed FFT output into natural bin order through a ping-pong frame store.
// Latency 2 ce cycles from the last word of a frame to bin 0; no backpressure, ce_i stalls everything.
module fft_bit_reverse
    import fft_bit_reverse_pkg::*;
#(
    parameter int FFT_N     = FMCW_FFT_N,
    parameter int FFT_NLOG2 = FMCW_FFT_NLOG2,
    parameter int DW        = FMCW_DW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic                 sync_i,
    input  logic [FFT_NLOG2-1:0] data_ctr_i,
    input  logic signed [DW-1:0] data_re_i,
    input  logic signed [DW-1:0] data_im_i,
    output logic                 valid_o,
    output logic [FFT_NLOG2-1:0] bin_o,
    output logic                 last_o,
    output logic signed [DW-1:0] data_re_o,
    output logic signed [DW-1:0] data_im_o
);

    localparam logic [FFT_NLOG2-1:0] LAST_IDX = FFT_NLOG2'(FFT_N - 1);

    logic                 wr_bank_q, wr_bank_d;
    logic                 pend_q, pend_d;
    logic                 rd_active_q, rd_active_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [FFT_NLOG2-1:0] rd_addr_q, rd_addr_d;
    logic                 valid_q, valid_d;
    logic [FFT_NLOG2-1:0] bin_q, bin_d;
    logic                 last_q, last_d;

    logic                 accept;
    logic                 frame_end;
    logic                 pass_end;
    logic                 start;
    logic [FFT_NLOG2-1:0] wr_addr;
    logic [2*DW-1:0]      rd_data;

    always_comb begin
        accept    = ce_i && sync_i;
        frame_end = accept && (data_ctr_i == LAST_IDX);
        pass_end  = rd_active_q && (rd_addr_q == LAST_IDX);
        // A filled bank may start its pass right as the previous pass issues its final address.
        start     = pend_q && (!rd_active_q || pass_end);
        wr_addr   = FFT_NLOG2'(bitrev(32'(data_ctr_i), FFT_NLOG2));

        wr_bank_d   = wr_bank_q ^ frame_end;
        pend_d      = pend_q;
        rd_active_d = rd_active_q;
        rd_bank_d   = rd_bank_q;
        rd_addr_d   = rd_addr_q;
        valid_d     = valid_q;
        bin_d       = bin_q;
        last_d      = last_q;

        if (ce_i) begin
            if (start) begin
                pend_d      = 1'b0;
                rd_active_d = 1'b1;
                rd_addr_d   = '0;
                rd_bank_d   = ~wr_bank_q;
            end else if (pass_end) begin
                rd_active_d = 1'b0;
            end else if (rd_active_q) begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
            if (frame_end) begin
                pend_d = 1'b1;
            end
            valid_d = rd_active_q;
            last_d  = pass_end;
            if (rd_active_q) begin
                bin_d = rd_addr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_bank_q   <= 1'b0;
            pend_q      <= 1'b0;
            rd_active_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            valid_q     <= 1'b0;
            bin_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            pend_q      <= pend_d;
            rd_active_q <= rd_active_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            valid_q     <= valid_d;
            bin_q       <= bin_d;
            last_q      <= last_d;
        end
    end

    fft_bitrev_ram #(
        .AW (FFT_NLOG2 + 1),
        .W  (2 * DW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (accept),
        .waddr_i ({wr_bank_q, wr_addr}),
        .wdata_i ({data_re_i, data_im_i}),
        .re_i    (ce_i && rd_active_q),
        .raddr_i ({rd_bank_q, rd_addr_q}),
        .rdata_o (rd_data)
    );

    assign valid_o                = valid_q;
    assign bin_o                  = bin_q;
    assign last_o                 = last_q;
    assign {data_re_o, data_im_o} = rd_data;

endmodule

// File: tb/tb_fft_bit_reverse.sv
// Scoreboard bench: stimulus pushes natural-order expectations, a monitor pops on every ce edge.
module tb_fft_bit_reverse;

    localparam int N  = 1024;
    localparam int LG = 10;
    localparam int DW = 25;

    logic                 clk_i = 1'b0;
    logic                 rst_i, ce_i, sync_i;
    logic [LG-1:0]        data_ctr_i;
    logic signed [DW-1:0] data_re_i, data_im_i;
    logic                 valid_o, last_o;
    logic [LG-1:0]        bin_o;
    logic signed [DW-1:0] data_re_o, data_im_o;

    always #5 clk_i = ~clk_i;

    fft_bit_reverse #(.FFT_N(N), .FFT_NLOG2(LG), .DW(DW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ce_i       (ce_i),
        .sync_i     (sync_i),
        .data_ctr_i (data_ctr_i),
        .data_re_i  (data_re_i),
        .data_im_i  (data_im_i),
        .valid_o    (valid_o),
        .bin_o      (bin_o),
        .last_o     (last_o),
        .data_re_o  (data_re_o),
        .data_im_o  (data_im_o)
    );

    typedef struct {
        int bin;
        int re;
        int im;
        bit last;
        bit vld;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0, n_err = 0;
    int   ce_cnt = 0, acc_ce = -100;
    int   run_len = 0, max_run = 0, last_cnt = 0;
    bit   ce_toggle = 1'b0, cap_en = 1'b0;
    int   cap_re[4];
    int   cap_im1, cap_re_last;

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < LG; i++) begin
            if (x[i]) r = r | (1 << (LG - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: samples inputs at the edge, outputs on the following falling edge.
    always begin : monitor
        logic          ce_s, rst_s, sync_s;
        logic [LG-1:0] ctr_s;
        exp_t          e;
        @(posedge clk_i);
        ce_s   = ce_i;
        rst_s  = rst_i;
        sync_s = sync_i;
        ctr_s  = data_ctr_i;
        if (!rst_s && ce_s) begin
            ce_cnt++;
            if (sync_s && ctr_s == LG'(N - 1)) acc_ce = ce_cnt;
        end
        @(negedge clk_i);
        if (rst_s) begin
            chk("rst_valid", int'(valid_o), 0);
            chk("rst_last", int'(last_o), 0);
            chk("rst_bin", int'(bin_o), 0);
            chk("rst_re", int'(data_re_o), 0);
            chk("rst_im", int'(data_im_o), 0);
            cur     = '{0, 0, 0, 1'b0, 1'b0};
            run_len = 0;
        end else if (!ce_s) begin
            chk("hold_valid", int'(valid_o), int'(cur.vld));
            if (cur.vld) begin
                chk("hold_bin", int'(bin_o), cur.bin);
                chk("hold_re", int'(data_re_o), cur.re);
                chk("hold_last", int'(last_o), int'(cur.last));
            end
        end else if (valid_o) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (last_o) last_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got valid word bin %0d re %0d, expected no output",
                         bin_o, data_re_o);
                cur.vld = 1'b0;
            end else begin
                e = exp_q.pop_front();
                chk("bin", int'(bin_o), e.bin);
                chk("re", int'(data_re_o), e.re);
                chk("im", int'(data_im_o), e.im);
                chk("last", int'(last_o), int'(e.last));
                if (e.bin == 0) chk("latency_ce", ce_cnt - acc_ce, 2);
                if (cap_en && e.bin < 4) cap_re[e.bin] = int'(data_re_o);
                if (cap_en && e.bin == 1) cap_im1 = int'(data_im_o);
                if (cap_en && e.bin == N - 1) cap_re_last = int'(data_re_o);
                cur     = e;
                cur.vld = 1'b1;
            end
        end else begin
            run_len = 0;
            cur.vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        ce_i = ce_toggle ? ~ce_i : 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            sync_i = 1'b0;
        end
    endtask

    task automatic send_word(input int ctr, input int val);
        do begin
            tick();
            sync_i     = 1'b1;
            data_ctr_i = LG'(ctr);
            data_re_i  = DW'(val);
            data_im_i  = DW'(-val);
        end while (!ce_i);
    endtask

    task automatic push_frame(input int frame);
        for (int k = 0; k < N; k++) begin
            exp_q.push_back('{k, frame * 4096 + brev(k), -(frame * 4096 + brev(k)), k == N - 1, 1'b1});
        end
    endtask

    task automatic send_frame(input int frame, input int gap_at);
        for (int c = 0; c < N; c++) begin
            if (c == gap_at) idle(100);
            send_word(c, frame * 4096 + c);
        end
        push_frame(frame);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            tick();
            sync_i = 1'b0;
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d words still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        idle(20);
    endtask

    task automatic clear_caps();
        for (int i = 0; i < 4; i++) cap_re[i] = -1;
        cap_im1     = -1;
        cap_re_last = -1;
        last_cnt    = 0;
        cap_en      = 1'b1;
    endtask

    // Hand-derived: bin k holds ctr bitrev(k), so bins 0..3 come from ctr 0,512,256,768.
    task automatic check_caps(input string name);
        cap_en = 1'b0;
        chk({name, "_bin0_re"}, cap_re[0], 0);
        chk({name, "_bin1_re"}, cap_re[1], 512);
        chk({name, "_bin2_re"}, cap_re[2], 256);
        chk({name, "_bin3_re"}, cap_re[3], 768);
        chk({name, "_bin1_im"}, cap_im1, -512);
        chk({name, "_bin1023_re"}, cap_re_last, 1023);
        chk({name, "_last_count"}, last_cnt, 1);
    endtask

    initial begin
        int n;
        rst_i      = 1'b1;
        ce_i       = 1'b0;
        sync_i     = 1'b0;
        data_ctr_i = '0;
        data_re_i  = '0;
        data_im_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(5);

        // Single continuous frame.
        clear_caps();
        send_frame(0, -1);
        drain("s1");
        check_caps("s1");

        // Three back-to-back frames must stream without a bubble.
        max_run  = 0;
        last_cnt = 0;
        send_frame(0, -1);
        send_frame(1, -1);
        send_frame(2, -1);
        drain("s2");
        chk("s2_valid_run", max_run, 3 * N);
        chk("s2_last_count", last_cnt, 3);

        // Alternating clock enable.
        ce_toggle = 1'b1;
        clear_caps();
        send_frame(0, -1);
        drain("s3");
        ce_toggle = 1'b0;
        check_caps("s3");

        // Upstream pause mid-frame.
        clear_caps();
        send_frame(0, 500);
        drain("s4");
        check_caps("s4");

        // Reset in the middle of a read pass, then a clean frame.
        send_frame(1, -1);
        n = 0;
        while (!(valid_o && bin_o == LG'(300)) && n < 3000) begin
            tick();
            sync_i = 1'b0;
            n++;
        end
        chk("s5_reached_bin300", int'(valid_o && bin_o == LG'(300)), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        idle(10);
        send_frame(2, -1);
        drain("s5");

        // Counter restarts at 0 after 700: the partial frame must never appear.
        for (int c = 0; c <= 700; c++) send_word(c, 7 * 4096 + c);
        send_frame(3, -1);
        drain("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_bit_reverse.md
FFT_BIT_REVERSE -- requirements
Module: fft_bit_reverse

Interface
REQ-001 SHALL have parameter FFT_N, default 1024, transform length (power of 4, matching the upstream R22SDF FFT).
REQ-002 SHALL have parameter FFT_NLOG2, default 10, log2(FFT_N).
REQ-003 SHALL have parameter DW, default 25, width of each real and imaginary sample.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port ce_i, input, 1, clock enable; when low, all state holds.
REQ-007 SHALL have port sync_i, input, 1, upstream FFT output-valid (connects to FFT sync_o).
REQ-008 SHALL have port data_ctr_i, input, FFT_NLOG2, upstream output index in bit-reversed order (connects to FFT data_ctr).
REQ-009 SHALL have ports data_re_i and data_im_i, input, DW each, signed upstream FFT output.
REQ-010 SHALL have port valid_o, output, 1, output word valid.
REQ-011 SHALL have port bin_o, output, FFT_NLOG2, natural-order bin index of the output word.
REQ-012 SHALL have port last_o, output, 1, high with bin_o == FFT_N-1.
REQ-013 SHALL have ports data_re_o and data_im_o, output, DW each, signed, natural-order spectrum.

Function
REQ-014 SHALL accept one input word per cycle in which ce_i && sync_i.
REQ-015 SHALL write each accepted word into the current write bank at address bitrev(data_ctr_i) over FFT_NLOG2 bits.
REQ-016 SHALL hold two banks of FFT_N complex words (ping-pong); the write bank toggles on acceptance of data_ctr_i == FFT_N-1.
REQ-017 SHALL, on that bank toggle, mark the just-filled bank ready and start a read pass on it in the next ce cycle.
REQ-018 SHALL read a pass sequentially, addresses 0..FFT_N-1, one per ce cycle, with no gaps.
REQ-019 SHALL have latency 2 ce cycles: accept of data_ctr_i == FFT_N-1 at edge t gives valid_o=1, bin_o=0 at edge t+2.
REQ-020 SHALL drive bin_o equal to the read address delayed to align with the registered RAM output; last_o SHALL be high only when bin_o == FFT_N-1.
REQ-021 SHALL allow a read pass and writes of the next frame to proceed concurrently in opposite banks.
REQ-022 SHALL rely on the fact that, with one write per ce cycle at most, a read pass always completes before the next bank toggle; no overflow logic is required.
REQ-023 SHALL, if sync_i drops mid-frame, hold the write position and resume on the next accepted word.
REQ-024 SHALL, if data_ctr_i == 0 is accepted before the frame completes, overwrite the same bank without toggling.
REQ-025 SHALL deassert valid_o after the word with bin_o == FFT_N-1, unless a new pass starts in the next ce cycle.
REQ-026 SHALL hold outputs unchanged while ce_i == 0.

Reset
REQ-027 SHALL, on rst_i high at a clock edge, set valid_o=0, last_o=0, bin_o=0, data_re_o=0, data_im_o=0, write bank=0, and no bank ready, regardless of ce_i.
REQ-028 SHALL abort any read pass in progress when reset occurs mid-pass; RAM contents need not be cleared.

Structure
REQ-029 SHALL take FFT_N, FFT_NLOG2 and DW from the shared FMCW defines header; the bit-reverse function SHALL also live there.
REQ-030 SHALL instantiate one sub-module, fft_bitrev_ram: simple dual-port, 2*FFT_N x 2*DW, one write port, registered read port, bank as the address MSB.

Verification
REQ-031 SHALL verify this scenario: FFT_N=1024; one frame with data_re_i = data_ctr_i, im = -data_ctr_i, ctr 0..1023 continuous -> bins 0,1,2,3 give re 0,512,256,768 and bin 1023 gives 1023; last_o appears exactly once.
REQ-032 SHALL verify this scenario: three back-to-back frames with re = frame*4096 + ctr -> valid_o high continuously for 3072 cycles, with no gaps, and frame order preserved.
REQ-033 SHALL verify this scenario: ce_i toggled 1,0,1,0 throughout one frame -> output identical to REQ-031 with each word held for two clocks, and the latency of REQ-019 counted in ce cycles.
REQ-034 SHALL verify this scenario: sync_i low for 100 cycles at ctr=500 -> output identical to REQ-031 once the frame completes.
REQ-035 SHALL verify this scenario: rst_i pulsed at output bin 300 -> valid_o=0 on the next edge with all outputs 0; the next complete frame is output correctly.
REQ-036 SHALL verify this scenario: ctr restarts at 0 after ctr=700 -> no output until the restarted frame reaches 1023, and then only the restarted frame's data appears.
